// File: rtl/apb_reg_bank.sv
// Parametrised APB slave register bank with wait states, PSLVERR, read-only masking and write pulses.
// Optional feature: define APB_PSTRB_EN to add the PSTRB port and byte-lane write masking.
module apb_reg_bank #(
   parameter int unsigned AMBA_WORD       = 32,
   parameter int unsigned AMBA_ADDR_WIDTH = 20,
   parameter int unsigned NUM_REGS        = 4,
   parameter int unsigned WAIT_STATES     = 0,
   parameter logic [NUM_REGS-1:0]           RO_MASK = '0,
   parameter logic [NUM_REGS*AMBA_WORD-1:0] RST_VAL = '0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            PSEL,
   input  logic                            PENABLE,
   input  logic                            PWRITE,
   input  logic [AMBA_ADDR_WIDTH-1:0]      PADDR,
   input  logic [AMBA_WORD-1:0]            PWDATA,
`ifdef APB_PSTRB_EN
   input  logic [AMBA_WORD/8-1:0]          PSTRB,
`endif
   output logic [AMBA_WORD-1:0]            PRDATA,
   output logic                            PREADY,
   output logic                            PSLVERR,
   output logic [NUM_REGS*AMBA_WORD-1:0]   regs,
   output logic [NUM_REGS-1:0]             wr_pulse,
   output logic                            start
);

   localparam int unsigned WCW  = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);
   localparam int unsigned IDXW = AMBA_ADDR_WIDTH - 2;
   localparam int unsigned NB   = AMBA_WORD / 8;

   typedef enum logic {IDLE, ACCESS} state_e;

   state_e                 state_q;
   logic [WCW-1:0]         wcnt_q;
   logic [AMBA_WORD-1:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]    wr_pulse_q;

   logic [IDXW-1:0]        idx;
   logic                   idx_ok;
   logic                   ro_hit;
   logic                   acc_err;
   logic                   xfer_done;
   logic [AMBA_WORD-1:0]   rd_word;
   logic [AMBA_WORD-1:0]   wr_word;

   assign idx = PADDR[AMBA_ADDR_WIDTH-1:2];
   assign idx_ok = (idx < IDXW'(NUM_REGS));

   // Select the addressed register and its read-only flag
   always_comb begin
      ro_hit  = 1'b0;
      rd_word = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (idx == IDXW'(i)) begin
            ro_hit  = RO_MASK[i];
            rd_word = regs_q[i];
         end
      end
   end

   // Merge write data into the current word; unstrobed lanes keep their old value
   always_comb begin
`ifdef APB_PSTRB_EN
      wr_word = rd_word;
      for (int unsigned b = 0; b < NB; b++) begin
         if (PSTRB[b]) wr_word[b*8 +: 8] = PWDATA[b*8 +: 8];
      end
`else
      wr_word = PWDATA;
`endif
   end

   assign acc_err   = (PADDR[1:0] != 2'b00) || !idx_ok || (PWRITE && ro_hit);
   assign xfer_done = (state_q == ACCESS) && PSEL && PENABLE && (wcnt_q == WCW'(WAIT_STATES));

   assign PREADY  = xfer_done;
   assign PSLVERR = xfer_done && acc_err;
   assign PRDATA  = (xfer_done && !acc_err && !PWRITE) ? rd_word : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wcnt_q     <= '0;
         wr_pulse_q <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RST_VAL[i*AMBA_WORD +: AMBA_WORD];
         end
      end else begin
         wr_pulse_q <= '0;
         case (state_q)
            IDLE: begin
               if (PSEL) begin
                  state_q <= ACCESS;
                  wcnt_q  <= '0;
               end
            end
            ACCESS: begin
               if (!PSEL || !PENABLE) begin
                  state_q <= IDLE;
               end else if (wcnt_q != WCW'(WAIT_STATES)) begin
                  wcnt_q <= wcnt_q + WCW'(1);
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
         // Commit a valid write and raise its pulse for the following cycle
         if (xfer_done && PWRITE && !acc_err) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
               if (idx == IDXW'(i)) begin
                  regs_q[i]     <= wr_word;
                  wr_pulse_q[i] <= 1'b1;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs[g*AMBA_WORD +: AMBA_WORD] = regs_q[g];
   end

   assign wr_pulse = wr_pulse_q;
   assign start    = wr_pulse_q[0];

endmodule

// File: tb/tb_apb_reg_bank.sv
// Scoreboard bench for apb_reg_bank: driver pushes expected responses, monitor checks each completion.
// Covers strobed writes when APB_PSTRB_EN is defined.
module tb_apb_reg_bank;

   localparam int unsigned WS = 2;
   localparam logic [3:0]   RO = 4'b0100;
   localparam logic [127:0] RSTV = {32'h1122_3344, 32'h1234_5678, 32'h0000_00A5, 32'h0000_0000};

   typedef struct {
      logic [31:0]  prdata;
      logic         slverr;
      int           waits;
      logic [3:0]   pulse;
      logic [127:0] regs_after;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          PSEL = 1'b0;
   logic          PENABLE = 1'b0;
   logic          PWRITE = 1'b0;
   logic [19:0]   PADDR = '0;
   logic [31:0]   PWDATA = '0;
`ifdef APB_PSTRB_EN
   logic [3:0]    PSTRB = 4'hF;
`endif
   logic [31:0]   PRDATA;
   logic          PREADY;
   logic          PSLVERR;
   logic [127:0]  regs;
   logic [3:0]    wr_pulse;
   logic          start;

   exp_t          q[$];
   logic [31:0]   mdl [4];
   int            ncmp = 0;
   int            nfail = 0;

   always #5 clk = ~clk;

   apb_reg_bank #(
      .AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .NUM_REGS(4), .WAIT_STATES(WS),
      .RO_MASK(RO), .RST_VAL(RSTV)
   ) dut (
      .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_PSTRB_EN
      .PSTRB(PSTRB),
`endif
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .regs(regs), .wr_pulse(wr_pulse), .start(start)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] flat();
      logic [127:0] f;
      for (int i = 0; i < 4; i++) f[i*32 +: 32] = mdl[i];
      return f;
   endfunction

   task automatic mdl_reset();
      for (int i = 0; i < 4; i++) mdl[i] = RSTV[i*32 +: 32];
   endtask

   // One full transfer, called and returning at posedge+1
   task automatic xfer(input logic wr, input logic [19:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
      exp_t e;
      int   idx;
      logic err;
      logic [3:0] eff;
      bit   done;
      eff = strb;
`ifndef APB_PSTRB_EN
      eff = 4'hF;
`endif
      idx = int'(addr >> 2);
      err = (addr[1:0] != 2'b00) || (idx >= 4) || (wr && (idx < 4) && RO[idx]);
      e.prdata = '0;
      e.slverr = err;
      e.waits  = WS;
      e.pulse  = '0;
      if (!err) begin
         if (wr) begin
            for (int b = 0; b < 4; b++) if (eff[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
            e.pulse = 4'(1 << idx);
         end else begin
            e.prdata = mdl[idx];
         end
      end
      e.regs_after = flat();
      q.push_back(e);

      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
`ifdef APB_PSTRB_EN
      PSTRB = strb;
`endif
      @(posedge clk); #1;
      PENABLE = 1'b1;
      done = 1'b0;
      for (int n = 0; n < 40 && !done; n++) begin
         @(negedge clk);
         if (PREADY) done = 1'b1;
         @(posedge clk); #1;
      end
      PSEL = 1'b0; PENABLE = 1'b0;
      if (!done) begin
         ncmp++; nfail++;
         $display("FAIL xfer_timeout: addr %0h got no PREADY within 40 cycles", addr);
      end
   endtask

   // Drop PSEL after one access cycle, inside the wait window
   task automatic abort_xfer(input logic wr, input logic [19:0] addr, input logic [31:0] data);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
      @(posedge clk); #1;
      PENABLE = 1'b1;
      @(posedge clk); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic reset_mid();
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 20'h4; PWDATA = $urandom;
      @(posedge clk); #1;
      PENABLE = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
      mdl_reset();
   endtask

   // Monitor: checks every cycle, pops the scoreboard on each completion
   initial begin
      logic [127:0] cur;
      logic [127:0] pend_regs;
      logic [3:0]   pend_pulse;
      bit           pend;
      int           wc;
      exp_t         e;
      cur = RSTV; pend = 1'b0; wc = 0; pend_regs = '0; pend_pulse = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete();
            pend = 1'b0; wc = 0; cur = RSTV;
         end else begin
            chk("wr_pulse", 128'(wr_pulse), pend ? 128'(pend_pulse) : 128'(0));
            chk("start", 128'(start), pend ? 128'(pend_pulse[0]) : 128'(0));
            chk("regs", regs, pend ? pend_regs : cur);
            if (pend) cur = pend_regs;
            pend = 1'b0;
            if (PSEL && PENABLE && PREADY) begin
               if (q.size() == 0) begin
                  ncmp++; nfail++;
                  $display("FAIL unexpected_pready: got PREADY=1 expected no transfer");
               end else begin
                  e = q.pop_front();
                  chk("prdata", 128'(PRDATA), 128'(e.prdata));
                  chk("pslverr", 128'(PSLVERR), 128'(e.slverr));
                  chk("wait_states", 128'(wc), 128'(e.waits));
                  pend = 1'b1; pend_pulse = e.pulse; pend_regs = e.regs_after;
               end
               wc = 0;
            end else begin
               chk("idle_prdata", 128'(PRDATA), 128'(0));
               chk("idle_pslverr", 128'(PSLVERR), 128'(0));
               if (PSEL && PENABLE) wc++;
               else wc = 0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          k;
      logic        wr;
      logic [19:0] a;
      mdl_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      xfer(1'b0, 20'h4, 32'h0, 4'hF);                 // reset value of reg1
      xfer(1'b1, 20'h0, 32'hDEAD_BEEF, 4'hF);         // control write raises start
      xfer(1'b0, 20'h0, 32'h0, 4'hF);
      xfer(1'b0, 20'h10, 32'h0, 4'hF);                // out of range
      xfer(1'b1, 20'h6, 32'h5555_5555, 4'hF);         // misaligned
      xfer(1'b1, 20'h8, 32'hFFFF_FFFF, 4'hF);         // read-only
      xfer(1'b0, 20'h8, 32'h0, 4'hF);
      xfer(1'b1, 20'hC, 32'hAABB_CCDD, 4'b0101);      // strobed when enabled
      xfer(1'b0, 20'hC, 32'h0, 4'hF);
      xfer(1'b1, 20'hC, 32'h0BAD_F00D, 4'b0000);      // empty strobe still pulses
      xfer(1'b1, 20'h0, 32'h0000_0001, 4'hF);         // back-to-back same register
      xfer(1'b1, 20'h0, 32'h0000_0002, 4'hF);
      abort_xfer(1'b1, 20'h4, 32'hCAFE_CAFE);
      xfer(1'b0, 20'h4, 32'h0, 4'hF);
      reset_mid();
      xfer(1'b0, 20'h0, 32'h0, 4'hF);

      for (int t = 0; t < 200; t++) begin
         k  = $urandom_range(0, 39);
         wr = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            5:       a = 20'($urandom_range(0, 3) * 4 + $urandom_range(1, 3));
            6:       a = 20'($urandom_range(4, 10) * 4);
            7:       a = 20'($urandom) & 20'hF_FFFC;
            default: a = 20'($urandom_range(0, 3) * 4);
         endcase
         if (k == 0)      reset_mid();
         else if (k < 4)  abort_xfer(wr, a, $urandom);
         else             xfer(wr, a, $urandom, 4'($urandom_range(0, 15)));
      end

      repeat (3) @(posedge clk);
      chk("queue_empty", 128'(q.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/apb_reg_bank.md
# apb_reg_bank

Parametrised APB slave register bank; successor to the fixed four-register APB slave on the control path. Provides NUM_REGS word registers with PREADY wait states, PSLVERR on bad or illegal accesses, per-register read-only masking, and per-register write pulses. Register 0 acts as the control register and raises `start` after every successful write to it.

## Interface
- AMBA_WORD, 32: data width; must be a multiple of 8.
- AMBA_ADDR_WIDTH, 20: PADDR width.
- NUM_REGS, 4: register count, 1..64; register i sits at byte address 4*i.
- WAIT_STATES, 0: PREADY-low cycles inserted per access, 0..15.
- RO_MASK, 0 (NUM_REGS bits): bit i set means register i is read-only.
- RST_VAL, 0 (NUM_REGS*AMBA_WORD bits): reset values; register i takes slice [i*AMBA_WORD +: AMBA_WORD].
- clk  in  1  clock; everything is clocked on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  AMBA_ADDR_WIDTH  byte address.
- PWDATA  in  AMBA_WORD  write data.
- PSTRB  in  AMBA_WORD/8  byte lane strobes; port exists only with APB_PSTRB_EN.
- PRDATA  out  AMBA_WORD  read data.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error response; valid only while PREADY=1.
- regs  out  NUM_REGS*AMBA_WORD  all register contents, flattened; register i = [i*AMBA_WORD +: AMBA_WORD].
- wr_pulse  out  NUM_REGS  one-cycle pulse per register after a successful write to it.
- start  out  1  equals wr_pulse[0].

## Operation
- FSM states:
  - IDLE: on PSEL=1, go to ACCESS and clear wait counter `wcnt`.
  - ACCESS with PSEL=0 or PENABLE=0: abort; go to IDLE; no register or pulse effect.
  - ACCESS with wcnt < WAIT_STATES: wcnt++ and stay.
  - ACCESS with wcnt == WAIT_STATES: transfer completes; go to IDLE.
- Decode: idx = PADDR[AMBA_ADDR_WIDTH-1:2].
- Error conditions: PADDR[1:0] != 0, idx >= NUM_REGS, or a write to a register with RO_MASK[idx] set.
- An erroring access asserts PSLVERR with PREADY, leaves all registers unchanged, drives PRDATA=0 and raises no pulse.
- Valid write: register idx takes PWDATA on the completing edge; wr_pulse[idx] is high for exactly the next cycle.
- Valid read: PRDATA = register idx during the completing cycle.
- Reads of read-only registers are legal and return their reset value.
- Outputs outside a completing cycle: PRDATA=0, PSLVERR=0, PREADY=0.
- Back-to-back transfers: the master's next setup phase lands in IDLE, so each transfer is setup cycle + (WAIT_STATES+1) access cycles with no dead cycle.

## Timing
- Reset (synchronous): state=IDLE, wcnt=0, regs=RST_VAL, wr_pulse=0, start=0, PRDATA=0, PREADY=0, PSLVERR=0.
- Reset asserted mid-transfer: the transfer is discarded and registers take RST_VAL.
- PREADY, PRDATA and PSLVERR are combinational from state, wcnt and the APB inputs. They carry no register delay.
- Write latency:
  - register visible on `regs` one cycle after the completing edge;
  - readable by the next transfer;
  - wr_pulse/start coincide with `regs` updating.
- wcnt is $clog2(WAIT_STATES+1) bits wide, minimum 1, and never wraps.
- Two writes to the same register in consecutive transfers give two separate wr_pulse cycles, since a transfer is at least 2 cycles long.

## Configuration
- APB_PSTRB_EN defined:
  - PSTRB port is present; only byte lanes with PSTRB[b]=1 are updated.
  - A write with PSTRB=0 completes without error, changes nothing, and still pulses wr_pulse[idx].
  - Reads ignore PSTRB.
- APB_PSTRB_EN undefined: no PSTRB port; every write updates the full word.

## Test plan
- Reset with RST_VAL reg1=0x0000_00A5, then read 0x4 -> PRDATA=0x0000_00A5, PSLVERR=0.
- WAIT_STATES=2: write 0xDEAD_BEEF to 0x0 -> PREADY low for 2 access cycles then high; regs[31:0]=0xDEAD_BEEF and start=1 for exactly one cycle after completion; read 0x0 returns 0xDEAD_BEEF.
- NUM_REGS=4: read 0x10, and separately write 0x6 -> each completes with PSLVERR=1 and PRDATA=0; all registers unchanged.
- RO_MASK=4'b0100, reg2=0x1234_5678: write 0xFFFF_FFFF to 0x8 -> PSLVERR=1, reg2 stays 0x1234_5678, wr_pulse=0.
- APB_PSTRB_EN, reg3=0x1122_3344: write 0xAABB_CCDD with PSTRB=4'b0101 -> reg3=0x11BB_33DD.
- Abort: drop PSEL during a wait state of a write to 0x4 -> FSM returns to IDLE, reg1 unchanged, no wr_pulse; rst asserted mid-access -> all outputs at reset values next cycle.
